// File: rtl/lp_filter_pkg.sv
// Shared types and helpers for the time-multiplexed multi-channel low-pass filter.
package lp_filter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lp_state_e;

  localparam int LP_DATA_BITS    = 28;
  localparam int LP_CHANNEL_BITS = 2;
  localparam int LP_MAX_STAGES   = 4;
  localparam int LP_SHIFT_W      = 4;
  localparam int LP_STAGE_W      = $clog2(LP_MAX_STAGES + 1);

  function automatic int stage_w(input int max_stages);
    return $clog2(max_stages + 1);
  endfunction

  // Requested stage counts above the configured maximum saturate.
  function automatic logic [3:0] clamp_stages(input logic [3:0] stages,
                                              input logic [3:0] max_stages);
    logic [3:0] res;
    if (stages > max_stages) begin
      res = max_stages;
    end else begin
      res = stages;
    end
    return res;
  endfunction

endpackage

// File: rtl/lp_filter_mux_if.sv
// Sample-in / result-out bundle of the multi-channel low-pass filter.
interface lp_filter_mux_if #(
  parameter int DATA_BITS    = 28,
  parameter int CHANNEL_BITS = 2,
  parameter int SHIFT_W      = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [CHANNEL_BITS-1:0] in_channel;
  logic [DATA_BITS-1:0]    in_value;
  logic [3:0]              stages;
  logic [SHIFT_W-1:0]      shift;
  logic                    out_valid;
  logic [CHANNEL_BITS-1:0] out_channel;
  logic [DATA_BITS-1:0]    out_value;

  modport master (
    output in_valid, in_channel, in_value, stages, shift,
    input  in_ready, out_valid, out_channel, out_value
  );

  modport slave (
    input  in_valid, in_channel, in_value, stages, shift,
    output in_ready, out_valid, out_channel, out_value
  );
endinterface

// File: rtl/lp_filter_mux_alu.sv
// Shared first-order IIR step: s' = s + ((x - s) >>> shift), or s' = x when priming.
module lp_filter_mux_alu
  import lp_filter_pkg::*;
#(
  parameter int DATA_BITS = LP_DATA_BITS,
  parameter int SHIFT_W   = LP_SHIFT_W
) (
  input  logic [DATA_BITS-1:0] x,
  input  logic [DATA_BITS-1:0] s,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic                 prime,
  output logic [DATA_BITS-1:0] s_next
);

  logic signed [DATA_BITS:0] diff_s;
  logic [DATA_BITS-1:0]      step_s;

  // The step is bounded by |x - s|, so the DATA_BITS-wide sum cannot wrap.
  always_comb begin
    diff_s = $signed({1'b0, x}) - $signed({1'b0, s});
    step_s = DATA_BITS'(diff_s >>> shift);
    if (prime) begin
      s_next = x;
    end else begin
      s_next = s + step_s;
    end
  end

endmodule

// File: rtl/lp_filter_mux.sv
// Multi-channel cascaded low-pass filter: one stage per cycle through a shared ALU,
// with per-channel/per-stage state in a small distributed RAM.
module lp_filter_mux
  import lp_filter_pkg::*;
#(
  parameter int DATA_BITS    = LP_DATA_BITS,
  parameter int CHANNEL_BITS = LP_CHANNEL_BITS,
  parameter int MAX_STAGES   = LP_MAX_STAGES,
  parameter int SHIFT_W      = LP_SHIFT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce,
  lp_filter_mux_if.slave  bus
);

  localparam int NCH     = 1 << CHANNEL_BITS;
  localparam int DEPTH   = NCH * MAX_STAGES;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int STAGE_W = stage_w(MAX_STAGES);

  lp_state_e               state_r;
  logic [CHANNEL_BITS-1:0] ch_r;
  logic [DATA_BITS-1:0]    x_r;
  logic [STAGE_W-1:0]      n_r;
  logic [STAGE_W-1:0]      k_r;
  logic [SHIFT_W-1:0]      shift_r;
  logic [STAGE_W-1:0]      pcnt_r [NCH];
  logic [DATA_BITS-1:0]    mem_r [DEPTH];

  logic                    out_valid_r;
  logic [CHANNEL_BITS-1:0] out_channel_r;
  logic [DATA_BITS-1:0]    out_value_r;

  logic [ADDR_W-1:0]       addr_s;
  logic [DATA_BITS-1:0]    s_s;
  logic [DATA_BITS-1:0]    s_next_s;
  logic [STAGE_W-1:0]      n_in_s;
  logic                    prime_s;
  logic                    last_s;
  logic                    we_s;

  assign n_in_s  = STAGE_W'(clamp_stages(bus.stages, 4'(MAX_STAGES)));
  assign addr_s  = ADDR_W'(ch_r) * ADDR_W'(MAX_STAGES) + ADDR_W'(k_r);
  assign s_s     = mem_r[addr_s];
  // Stages at or beyond the channel's primed count hold stale memory and restart from x.
  assign prime_s = (k_r >= pcnt_r[ch_r]);
  assign last_s  = (k_r == n_r - STAGE_W'(1));
  assign we_s    = ce & ~reset & (state_r == ST_RUN);

  assign bus.in_ready    = (state_r == ST_IDLE);
  assign bus.out_valid   = out_valid_r;
  assign bus.out_channel = out_channel_r;
  assign bus.out_value   = out_value_r;

  lp_filter_mux_alu #(
    .DATA_BITS (DATA_BITS),
    .SHIFT_W   (SHIFT_W)
  ) u_alu (
    .x      (x_r),
    .s      (s_s),
    .shift  (shift_r),
    .prime  (prime_s),
    .s_next (s_next_s)
  );

  // Filter state write-back, one stage per RUN cycle.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[addr_s] <= s_next_s;
    end
  end

  // Sequencer: accept, step through the stages, register the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      ch_r          <= '0;
      x_r           <= '0;
      n_r           <= '0;
      k_r           <= '0;
      shift_r       <= '0;
      out_valid_r   <= 1'b0;
      out_channel_r <= '0;
      out_value_r   <= '0;
      for (int i = 0; i < NCH; i++) begin
        pcnt_r[i] <= '0;
      end
    end else if (ce) begin
      out_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (n_in_s == STAGE_W'(0)) begin
              out_valid_r   <= 1'b1;
              out_value_r   <= bus.in_value;
              out_channel_r <= bus.in_channel;
            end else begin
              ch_r    <= bus.in_channel;
              x_r     <= bus.in_value;
              n_r     <= n_in_s;
              shift_r <= bus.shift;
              k_r     <= STAGE_W'(0);
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          x_r <= s_next_s;
          if (prime_s) begin
            pcnt_r[ch_r] <= k_r + STAGE_W'(1);
          end
          if (last_s) begin
            out_valid_r   <= 1'b1;
            out_value_r   <= s_next_s;
            out_channel_r <= ch_r;
            state_r       <= ST_IDLE;
          end else begin
            k_r <= k_r + STAGE_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
